// File: rtl/fetch_queue.sv
// Instruction-fetch stage: launches one read at a time to instruction memory
// and buffers returned words with their fetch address in a prefetch FIFO.
module fetch_queue #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        pc_in,
    output logic                     pc_advance,
    input  logic                     flush,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DISCARD} state_t;

    state_t             state;
    state_t             state_n;
    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  addr_q;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [DATA_W-1:0]  instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];

    // A slot is reserved at launch, so the full check ignores any same-cycle pop
    assign pc_advance = (state == IDLE) && (count < CNT_W'(DEPTH)) && !flush && !reset;
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready && !flush;
    assign mem_addr   = addr_q;
    assign out_instr  = instr_mem[rd_ptr];
    assign out_pc     = pc_mem[rd_ptr];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and push decode
    always_comb begin
        state_n = state;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (pc_advance) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_n = flush ? DISCARD : WAIT;
                end else if (flush) begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    // a response landing with the flush is dropped on the spot
                    state_n = mem_rvalid ? IDLE : DISCARD;
                end else if (mem_rvalid) begin
                    state_n = IDLE;
                    push    = 1'b1;
                end
            end
            DISCARD: begin
                if (mem_rvalid) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Request, address and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req <= 1'b0;
            addr_q  <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            mem_req <= (state_n == ISSUE);
            if (pc_advance) begin
                addr_q <= pc_in;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage; contents are meaningless while the slot is not counted
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]    <= addr_q;
        end
    end

endmodule
